// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU front end: select codes,
// the controller state type and the captured request record.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;
  localparam logic [3:0] OP_MOD = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h8;
  localparam logic [3:0] OP_SHL = 4'h9;
  localparam logic [3:0] OP_SHR = 4'hA;
  localparam logic [3:0] OP_ROL = 4'hB;
  localparam logic [3:0] OP_ROR = 4'hC;
  localparam logic [3:0] OP_LT  = 4'hD;
  localparam logic [3:0] OP_GT  = 4'hE;
  localparam logic [3:0] OP_EQ  = 4'hF;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       id;
  } req_t;

  // Divide by zero is answered locally and never reaches the ALU.
  function automatic logic is_div0(input req_t r);
    return (r.op == OP_DIV) && (r.b == 8'h00);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the pointer remembers the last winner.
// A grant is always taken by the requester, so it doubles as the accept.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic last_q;

  always_comb begin
    grant = req;
    if (&req) grant = last_q ? 2'b01 : 2'b10;
  end

  // Reset value 1 makes requester 0 the winner of the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n)        last_q <= 1'b1;
    else if (grant[0]) last_q <= 1'b0;
    else if (grant[1]) last_q <= 1'b1;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two valid/ready requesters and returns
// each result on a single response channel tagged with the owner id.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter logic [7:0] DIV0_RESULT = 8'hFF,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [7:0]       req0_a,
  input  logic [7:0]       req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [7:0]       req1_a,
  input  logic [7:0]       req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [7:0]       rsp_result,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_select,
  input  logic [7:0]       alu_out,
  input  logic             alu_carry,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  state_t     state_q, state_d;
  logic [1:0] arb_req, grant;
  logic       accept;
  req_t       sel_req;
  logic [3:0] cur_op;

  assign arb_req = {req1_valid, req0_valid} & {2{state_q == IDLE}};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (arb_req),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = |grant;
  assign rsp_valid  = (state_q == RESP);
  assign busy       = (state_q != IDLE);

  always_comb begin
    sel_req = '{op: req0_op, a: req0_a, b: req0_b, id: 1'b0};
    if (grant[1]) sel_req = '{op: req1_op, a: req1_a, b: req1_b, id: 1'b1};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = is_div0(sel_req) ? RESP : ISSUE;
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // alu_* only move on a non-div0 accept, so they hold across IDLE and
  // stay stable through CAPTURE where the combinational carry is sampled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_op     <= OP_ADD;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      alu_select <= 4'h0;
      rsp_id     <= 1'b0;
      rsp_result <= 8'h00;
      rsp_carry  <= 1'b0;
      rsp_err    <= 1'b0;
      op_count   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            cur_op <= sel_req.op;
            rsp_id <= sel_req.id;
            if (is_div0(sel_req)) begin
              rsp_result <= DIV0_RESULT;
              rsp_err    <= 1'b1;
              rsp_carry  <= 1'b0;
            end else begin
              alu_a      <= sel_req.a;
              alu_b      <= sel_req.b;
              alu_select <= sel_req.op;
            end
          end
        end
        CAPTURE: begin
          rsp_result <= alu_out;
          rsp_carry  <= (cur_op == OP_ADD) && alu_carry;
          rsp_err    <= 1'b0;
        end
        RESP: begin
          if (rsp_ready) op_count <= op_count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU stand-in; a
// second, narrow-counter instance shares all inputs to observe counter wrap.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid, rsp_ready;
  logic [3:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_carry, rsp_err, busy;
  logic [7:0] rsp_result, alu_a, alu_b, alu_out;
  logic [3:0] alu_select;
  logic       alu_carry;
  logic [15:0] op_count;

  logic       s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id, s_rsp_carry, s_rsp_err, s_busy;
  logic [7:0] s_rsp_result, s_alu_a, s_alu_b;
  logic [3:0] s_alu_select;
  logic [3:0] s_op_count;

  int   n_checks = 0;
  int   n_fail = 0;
  int   model_count;
  logic model_last;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_out(alu_out), .alu_carry(alu_carry),
    .busy(busy), .op_count(op_count)
  );

  alu_arbiter #(.CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id), .rsp_result(s_rsp_result),
    .rsp_carry(s_rsp_carry), .rsp_err(s_rsp_err),
    .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_select(s_alu_select), .alu_out(alu_out), .alu_carry(alu_carry),
    .busy(s_busy), .op_count(s_op_count)
  );

  function automatic logic [7:0] ref_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MUL:  return a * b;
      OP_DIV:  return (b == 8'h00) ? 8'hFF : a / b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return 8'h00;
    endcase
  endfunction

  // ALU stand-in: registered result, raw add carry regardless of select.
  logic [8:0] alu_sum;
  assign alu_sum   = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_carry = alu_sum[8];
  always_ff @(posedge clk) alu_out <= ref_alu(alu_select, alu_a, alu_b);

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_op = 4'h0; req0_a = 8'h00; req0_b = 8'h00;
    req1_valid = 1'b0; req1_op = 4'h0; req1_a = 8'h00; req1_b = 8'h00;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1'b1;
    model_count = 0;
  endtask

  // Presents requests at a negedge, completes one transaction and reports
  // what was seen; a requester left waiting scrambles its op while busy.
  task automatic run_txn(input bit v0, input logic [3:0] op0, input logic [7:0] a0, input logic [7:0] b0,
                         input bit v1, input logic [3:0] op1, input logic [7:0] a1, input logic [7:0] b1,
                         input bit late1, input int stall,
                         output logic [1:0] gnt, output int lat, output logic rid, output logic [7:0] res,
                         output logic car, output logic err, output bit unstable, output bit leak);
    int  w;
    bit  keep0, keep1;
    unstable = 1'b0; leak = 1'b0;
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    #1 gnt = {req1_ready, req0_ready};
    w = 0;
    while (gnt == 2'b00 && w < 10) begin
      @(negedge clk);
      #1 gnt = {req1_ready, req0_ready};
      w++;
    end
    @(posedge clk);
    @(negedge clk);
    keep0 = v0 && !gnt[0];
    keep1 = (v1 && !gnt[1]) || late1;
    req0_valid = keep0; req1_valid = keep1;
    if (keep0) req0_op = 4'($urandom);
    if (keep1) req1_op = 4'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      leak = leak | req0_ready | req1_ready;
      @(negedge clk);
      lat++;
    end
    leak = leak | req0_ready | req1_ready;
    req0_op = op0; req1_op = op1;
    rid = rsp_id; res = rsp_result; car = rsp_carry; err = rsp_err;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      unstable = unstable | (rsp_valid !== 1'b1) | (rsp_result !== res) | (rsp_id !== rid)
                 | (rsp_carry !== car) | (rsp_err !== err);
      leak = leak | req0_ready | req1_ready;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (op_count !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_op_count got %0d want 0", op_count); end
    n_checks++; if ({alu_a, alu_b, alu_select} !== 20'h0) begin n_fail++; $display("[TB] FAIL reset_alu got %h/%h/%h want 0", alu_a, alu_b, alu_select); end
    n_checks++; if ({rsp_id, rsp_result, rsp_carry, rsp_err} !== 11'h0) begin n_fail++; $display("[TB] FAIL reset_rsp_fields got id=%b res=%h c=%b e=%b want 0", rsp_id, rsp_result, rsp_carry, rsp_err); end
    n_checks++; if ({req1_ready, req0_ready} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_ready got %b want 00", {req1_ready, req0_ready}); end
  endtask

  task automatic test_single_add();
    logic [1:0] g; int lat; logic id, c, e; logic [7:0] r; bit u, lk;
    do_reset();
    run_txn(1, OP_ADD, 8'hF0, 8'h20, 0, 4'h0, 8'h00, 8'h00, 0, 0, g, lat, id, r, c, e, u, lk);
    n_checks++; if (g !== 2'b01) begin n_fail++; $display("[TB] FAIL add_grant got %b want 01", g); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("[TB] FAIL add_latency got %0d want 3", lat); end
    n_checks++; if ({id, r, c, e} !== {1'b0, 8'h10, 1'b1, 1'b0}) begin n_fail++; $display("[TB] FAIL add_rsp got id=%b res=%h c=%b e=%b want id=0 res=10 c=1 e=0", id, r, c, e); end
    n_checks++; if (op_count !== 16'd1) begin n_fail++; $display("[TB] FAIL add_op_count got %0d want 1", op_count); end
    n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL add_after_hs got valid=%b busy=%b want 0 0", rsp_valid, busy); end
  endtask

  task automatic test_both_valid();
    logic [1:0] g; int lat; logic id, c, e, exp_id; logic [7:0] r; bit u, lk;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      run_txn(1, OP_AND, 8'hCC, 8'hAA, 1, OP_XOR, 8'hCC, 8'hAA, 0, 0, g, lat, id, r, c, e, u, lk);
      exp_id = model_last ? 1'b0 : 1'b1;
      model_last = exp_id;
      model_count++;
      n_checks++; if (g !== (exp_id ? 2'b10 : 2'b01) || id !== exp_id) begin n_fail++; $display("[TB] FAIL rr_grant[%0d] got grant=%b id=%b want id=%b", i, g, id, exp_id); end
      n_checks++; if (r !== (exp_id ? 8'h66 : 8'h88) || lat !== 3 || lk) begin n_fail++; $display("[TB] FAIL rr_result[%0d] got res=%h lat=%0d leak=%b want res=%h lat=3 leak=0", i, r, lat, lk, exp_id ? 8'h66 : 8'h88); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_checks++; if (op_count !== 16'(model_count)) begin n_fail++; $display("[TB] FAIL rr_op_count got %0d want %0d", op_count, model_count); end
  endtask

  task automatic test_div0();
    logic [1:0] g; int lat; logic id, c, e; logic [7:0] r; bit u, lk;
    do_reset();
    run_txn(1, OP_ADD, 8'h01, 8'h02, 0, 4'h0, 8'h00, 8'h00, 0, 0, g, lat, id, r, c, e, u, lk);
    run_txn(0, 4'h0, 8'h00, 8'h00, 1, OP_DIV, 8'h10, 8'h00, 0, 0, g, lat, id, r, c, e, u, lk);
    n_checks++; if (lat !== 1) begin n_fail++; $display("[TB] FAIL div0_latency got %0d want 1", lat); end
    n_checks++; if ({id, r, c, e} !== {1'b1, 8'hFF, 1'b0, 1'b1}) begin n_fail++; $display("[TB] FAIL div0_rsp got id=%b res=%h c=%b e=%b want id=1 res=ff c=0 e=1", id, r, c, e); end
    n_checks++; if (alu_select !== OP_ADD || alu_b !== 8'h02 || alu_a !== 8'h01) begin n_fail++; $display("[TB] FAIL div0_alu_held got sel=%h a=%h b=%h want 0/01/02", alu_select, alu_a, alu_b); end
    n_checks++; if (op_count !== 16'd2) begin n_fail++; $display("[TB] FAIL div0_op_count got %0d want 2", op_count); end
  endtask

  task automatic test_backpressure();
    logic [1:0] g; int lat; logic id, c, e; logic [7:0] r; bit u, lk;
    do_reset();
    run_txn(1, OP_SUB, 8'h05, 8'h03, 0, OP_XOR, 8'h11, 8'h22, 1, 5, g, lat, id, r, c, e, u, lk);
    req1_valid = 1'b0;
    n_checks++; if ({id, r, c, e} !== {1'b0, 8'h02, 1'b0, 1'b0} || lat !== 3) begin n_fail++; $display("[TB] FAIL bp_rsp got id=%b res=%h c=%b e=%b lat=%0d want 0/02/0/0 lat=3", id, r, c, e, lat); end
    n_checks++; if (u) begin n_fail++; $display("[TB] FAIL bp_stable got unstable=%b want 0", u); end
    n_checks++; if (lk) begin n_fail++; $display("[TB] FAIL bp_ready_while_busy got %b want 0", lk); end
    n_checks++; if (op_count !== 16'd1 || rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_complete got count=%0d valid=%b want 1 0", op_count, rsp_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req0_valid = 1'b1; req0_op = OP_MUL; req0_a = 8'h07; req0_b = 8'h03;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_capture got busy=%b valid=%b want 1 0", busy, rsp_valid); end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1'b1; model_count = 0;
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || op_count !== 16'h0) begin n_fail++; $display("[TB] FAIL mid_reset_state got busy=%b valid=%b count=%0d want 0 0 0", busy, rsp_valid, op_count); end
    n_checks++; if ({alu_a, alu_b, alu_select} !== 20'h0) begin n_fail++; $display("[TB] FAIL mid_reset_alu got %h/%h/%h want 0", alu_a, alu_b, alu_select); end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_checks++; if ({req1_ready, req0_ready} !== 2'b01) begin n_fail++; $display("[TB] FAIL mid_reset_grant got %b want 01", {req1_ready, req0_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_wrap();
    logic [1:0] g; int lat; logic id, c, e; logic [7:0] r; bit u, lk;
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      run_txn(1, OP_DIV, 8'(i), 8'h00, 0, 4'h0, 8'h00, 8'h00, 0, 0, g, lat, id, r, c, e, u, lk);
      model_count++;
      n_checks++; if (s_op_count !== 4'(model_count) || op_count !== 16'(model_count)) begin n_fail++; $display("[TB] FAIL wrap_count[%0d] got narrow=%0d wide=%0d want %0d %0d", i, s_op_count, op_count, model_count % 16, model_count); end
    end
  endtask

  task automatic test_random();
    logic [1:0] g; int lat; logic id, c, e; logic [7:0] r; bit u, lk;
    logic [3:0] ops [7] = '{OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR};
    logic [3:0] o0, o1, eo; logic [7:0] a0, b0, a1, b1, ea, eb; bit v0, v1; logic exp_id;
    logic [8:0] s; int st;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      v0 = 1'($urandom); v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      o0 = ops[$urandom_range(0, 6)]; o1 = ops[$urandom_range(0, 6)];
      a0 = 8'($urandom); a1 = 8'($urandom);
      b0 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      b1 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      st = $urandom_range(0, 3);
      run_txn(v0, o0, a0, b0, v1, o1, a1, b1, 0, st, g, lat, id, r, c, e, u, lk);
      exp_id = (v0 && v1) ? !model_last : v1;
      model_last = exp_id;
      model_count++;
      eo = exp_id ? o1 : o0; ea = exp_id ? a1 : a0; eb = exp_id ? b1 : b0;
      s = {1'b0, ea} + {1'b0, eb};
      n_checks++; if (id !== exp_id || g !== (exp_id ? 2'b10 : 2'b01)) begin n_fail++; $display("[TB] FAIL rnd_grant[%0d] got grant=%b id=%b want id=%b", i, g, id, exp_id); end
      n_checks++; if (r !== ref_alu(eo, ea, eb)) begin n_fail++; $display("[TB] FAIL rnd_result[%0d] op=%h a=%h b=%h got %h want %h", i, eo, ea, eb, r, ref_alu(eo, ea, eb)); end
      n_checks++; if (c !== ((eo == OP_ADD) && s[8]) || e !== ((eo == OP_DIV) && (eb == 8'h00))) begin n_fail++; $display("[TB] FAIL rnd_flags[%0d] got c=%b e=%b want c=%b e=%b", i, c, e, (eo == OP_ADD) && s[8], (eo == OP_DIV) && (eb == 8'h00)); end
      n_checks++; if (lat !== (((eo == OP_DIV) && (eb == 8'h00)) ? 1 : 3) || u || lk) begin n_fail++; $display("[TB] FAIL rnd_timing[%0d] got lat=%0d unstable=%b leak=%b", i, lat, u, lk); end
      n_checks++; if (op_count !== 16'(model_count)) begin n_fail++; $display("[TB] FAIL rnd_op_count[%0d] got %0d want %0d", i, op_count, model_count); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout got no finish want finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_single_add();
    test_both_valid();
    test_div0();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 8-bit registered ALU (4-bit select, 1-cycle result latency, combinational add-carry) between two requesters.
- Round-robin arbitration, valid/ready request and response channels.
- Drives ALU operands/select from registers and captures the result.
- Traps divide-by-zero without issuing it to the ALU.
- Sits between the two issuing agents and the ALU instance.

Parameters:
- DIV0_RESULT, 8'hFF, result returned for select 4'b0011 with B == 0.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset; single clock domain
- req0_valid  input  1  requester 0 has an op
- req0_ready  output  1  requester 0 op accepted this cycle when both valid and ready are high
- req0_op  input  4  ALU select code for requester 0
- req0_a, req0_b  input  8 each  requester 0 operands
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same widths and meanings, requester 1
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer takes response
- rsp_id  output  1  index of the requester that owns the response
- rsp_result  output  8  ALU result
- rsp_carry  output  1  carry out; valid for op 4'b0000 only, otherwise 0
- rsp_err  output  1  divide-by-zero trapped
- alu_a, alu_b  output  8 each  registered operands to ALU
- alu_select  output  4  registered select to ALU
- alu_out  input  8  ALU registered result
- alu_carry  input  1  ALU combinational carry
- busy  output  1  high in any state other than IDLE
- op_count  output  CNT_W  number of completed responses; wraps at 2^CNT_W

Behaviour:
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- Reset (rst_n low at a clk edge), applying from any state including mid-operation:
  - state goes to IDLE; the in-flight op is discarded.
  - rsp_valid, rsp_id, rsp_result, rsp_carry and rsp_err all go to 0.
  - alu_a, alu_b and alu_select go to 0; op_count goes to 0; busy goes to 0.
  - Round-robin pointer is set to favour req0.
- Grant (combinational):
  - reqN_ready is high only in IDLE and only for the granted requester.
  - Only one requester may be granted per cycle.
  - If only one requester is valid, that requester is granted.
  - If both are valid, the requester not granted last is granted; after reset, req0 wins.
  - The pointer updates only on an accepted request.
- Accept at cycle T (IDLE):
  - Latch op, a, b and id.
  - If op == 4'b0011 and b == 0: set rsp_result=DIV0_RESULT, rsp_err=1, rsp_carry=0, and go to RESP. rsp_valid is high at T+1. The ALU is not driven with the new operands.
  - Otherwise: drive alu_a/alu_b/alu_select from the latched values, then go to ISSUE. These values are valid from T+1.
- ISSUE (T+1):
  - alu_* held stable; the ALU registers its result at the end of T+1.
  - Unconditionally advance to CAPTURE.
- CAPTURE (T+2):
  - alu_out is valid; alu_* are still held, so alu_carry is valid.
  - Register rsp_result=alu_out and rsp_carry=(op==0)?alu_carry:0, with rsp_err=0.
  - Go to RESP.
- RESP (T+3 normal, T+1 div0):
  - rsp_valid=1; all rsp_* fields stay stable until rsp_ready is sampled high.
  - On rsp_valid & rsp_ready: rsp_valid goes to 0, op_count increments, and the FSM returns to IDLE.
  - Accept-to-response latency is therefore 3 cycles normal, 1 cycle for div0.
- rsp_ready has no effect while rsp_valid is low.
- Requests arriving while busy are not accepted; the requester must hold valid and its fields stable until ready.
- Best-case throughput: one op per 4 cycles (normal) or 2 cycles (div0). IDLE always lasts at least one cycle.
- alu_* hold their last values while IDLE; they change only on a non-div0 accept.

Decomposition:
- Package alu_pkg holds:
  - select-code localparams: OP_ADD=4'b0000, OP_SUB, OP_MUL, OP_DIV=4'b0011, … OP_EQ=4'b1111.
  - FSM state enum: IDLE/ISSUE/CAPTURE/RESP.
  - request struct: op, a, b, id.
- One sub-module, rr_arb2: a 2-way round-robin grant with a pointer update on accept.
- FSM, operand registers and response registers stay in alu_arbiter.

Test Plan:
- Reset, then req0 ADD a=8'hF0 b=8'h20 → req0_ready at T; rsp_valid at T+3 with rsp_id=0, rsp_result=8'h10, rsp_carry=1, rsp_err=0; op_count=1 after the handshake.
- Both valid every cycle: req0 AND 8'hCC/8'hAA, req1 XOR 8'hCC/8'hAA → grant order req0, req1, req0, …; results 8'h88 (id 0) and 8'h66 (id 1) alternate; req1_op changed while not ready is ignored.
- req1 DIV a=8'h10 b=8'h00 → rsp_valid at T+1 with rsp_result=8'hFF, rsp_err=1, rsp_carry=0; alu_select and alu_b unchanged from the previous op.
- req0 SUB 8'h05/8'h03 with rsp_ready held low 5 cycles → rsp_result=8'h02 and rsp_carry=0 stay stable; req1_ready stays 0 throughout; response completes when rsp_ready rises.
- rst_n pulsed low during CAPTURE of a MUL → next cycle state is IDLE, rsp_valid=0, op_count=0, alu_*=0; the following both-valid cycle grants req0.
- 65536 completed ops → op_count wraps to 0.
